// File: rtl/sync_mp_ram.sv
// Multi-read-port RAM: one byte-masked write port, NUM_RD registered read ports, post-reset clear sweep.
// Define SYNC_MP_RAM_BYPASS_EN for write-first data on same-cycle read/write collisions (default read-first).
module sync_mp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic                         ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [ADDR_WIDTH-1:0]        clr_addr;
    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    logic [NUM_RD*DATA_WIDTH-1:0] rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (&clr_addr) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        ready = (state == READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                clr_addr <= '0;
        else if (state == INIT) clr_addr <= clr_addr + 1'b1;
    end

    // While reset is held the sweep just keeps rewriting word 0 with zero, which is harmless.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_word[p*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef SYNC_MP_RAM_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                for (int i = 0; i < NB; i++)
                    if (wr_be[i]) rd_word[p*DATA_WIDTH + 8*i +: 8] = wr_data[8*i +: 8];
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else if (state == INIT) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++)
                if (rd_en[p]) rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p*DATA_WIDTH +: DATA_WIDTH];
            rd_valid <= rd_en;
        end
    end

endmodule
